// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift/correct per clock.
// Latency: start edge N -> done during the cycle after edge N+WIDTH; bad digit -> done after edge N.
// Backpressure: start is only accepted while ready=1; starts during CONV/DONE are dropped.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            conversion request, sampled while ready=1
//   D0..D4           BCD digits, D0 = units ... D4 = ten-thousands
//   ready            high in IDLE
//   done             one-cycle pulse, result outputs valid
//   Binary           converted value mod 2^WIDTH, held until the next result
//   err_digit        an input digit was > 9
//   overflow         decimal value exceeded 2^WIDTH-1
module bcd_to_binary_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       D0,
  input  logic [3:0]       D1,
  input  logic [3:0]       D2,
  input  logic [3:0]       D3,
  input  logic [3:0]       D4,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Binary,
  output logic             err_digit,
  output logic             overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   binary_q, binary_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;

  logic               digit_bad;
  logic [BCD_W+WIDTH-1:0] shift_all;
  logic [BCD_W-1:0]   sh_bcd;
  logic [WIDTH-1:0]   sh_bin;
  logic [BCD_W-1:0]   cor_bcd;

  assign digit_bad = (D0 > 4'd9) || (D1 > 4'd9) || (D2 > 4'd9) ||
                     (D3 > 4'd9) || (D4 > 4'd9);

  // One reverse double-dabble step: shift the combined register right,
  // then pull every digit that became >= 8 back down by 3.
  always_comb begin
    shift_all = {bcd_q, bin_q} >> 1;
    sh_bcd    = shift_all[BCD_W+WIDTH-1:WIDTH];
    sh_bin    = shift_all[WIDTH-1:0];
    cor_bcd   = sh_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd8) begin
        cor_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    count_d  = count_q;
    binary_d = binary_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (digit_bad) begin
            // Invalid operand: report immediately without iterating.
            err_d    = 1'b1;
            ovf_d    = 1'b0;
            binary_d = '0;
            state_d  = S_DONE;
          end else begin
            bcd_d   = {D4, D3, D2, D1, D0};
            bin_d   = '0;
            count_d = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        bcd_d   = cor_bcd;
        bin_d   = sh_bin;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          // Whatever decimal weight is left above bit WIDTH-1 means overflow.
          binary_d = sh_bin;
          ovf_d    = |cor_bcd;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      count_q  <= '0;
      binary_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      count_q  <= count_d;
      binary_q <= binary_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign Binary    = binary_q;
  assign err_digit = err_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
module tb_bcd_to_binary_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  D0, D1, D2, D3, D4;
  logic        ready;
  logic        done;
  logic [15:0] Binary;
  logic        err_digit;
  logic        overflow;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] bin;
    logic        err;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  bcd_to_binary_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .D0        (D0),
    .D1        (D1),
    .D2        (D2),
    .D3        (D3),
    .D4        (D4),
    .ready     (ready),
    .done      (done),
    .Binary    (Binary),
    .err_digit (err_digit),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic, result pushed to the scoreboard.
  task automatic push_exp(input logic [3:0] d4, d3, d2, d1, d0);
    exp_t e;
    int   v;
    e.err = (d4 > 9) || (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
    v = d4 * 10000 + d3 * 1000 + d2 * 100 + d1 * 10 + d0;
    if (e.err) begin
      e.bin = 16'h0;
      e.ovf = 1'b0;
      e.lat = 0;
    end else begin
      e.bin = v[15:0];
      e.ovf = (v > 65535);
      e.lat = 16;
    end
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("ready_before_start", {31'd0, ready}, 32'd1);
  endtask

  // Drive one conversion, optionally disturbing start/digits at cycle 'disturb'
  // after the start edge, then compare the result against the scoreboard.
  task automatic run_conv(input logic [3:0] d4, d3, d2, d1, d0, input int disturb);
    exp_t e;
    bit   got;
    wait_ready();
    D4 = d4; D3 = d3; D2 = d2; D1 = d1; D0 = d0;
    start = 1'b1;
    push_exp(d4, d3, d2, d1, d0);
    got = 0;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 1 && sb.size() > 0 && !sb[0].err)
        check_val("ready_low_in_conv", {31'd0, ready}, 32'd0);
      if (disturb > 0 && k == disturb) begin
        D4 = 4'd9; D3 = 4'd8; D2 = 4'd7; D1 = 4'd6; D0 = 4'd5;
        start = 1'b1;
      end
      if (disturb > 0 && k == disturb + 1) start = 1'b0;
      if (done) begin
        if (sb.size() == 0) begin
          check_val("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("binary", {16'd0, Binary}, {16'd0, e.bin});
          check_val("err_digit", {31'd0, err_digit}, {31'd0, e.err});
          check_val("overflow", {31'd0, overflow}, {31'd0, e.ovf});
          check_val("latency", k, e.lat);
        end
        got = 1;
        break;
      end
    end
    if (!got) begin
      check_val("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    start = 1'b0;
    @(negedge clk);
    check_val("done_single_pulse", {31'd0, done}, 32'd0);
    check_val("ready_after_done", {31'd0, ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check_val({tag, "_done"}, {31'd0, done}, 32'd0);
    check_val({tag, "_binary"}, {16'd0, Binary}, 32'd0);
    check_val({tag, "_err"}, {31'd0, err_digit}, 32'd0);
    check_val({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    int dones;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    D0 = 4'd0; D1 = 4'd0; D2 = 4'd0; D3 = 4'd0; D4 = 4'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    run_conv(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0);
    run_conv(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 0);   // 0x3039
    run_conv(4'd6, 4'd5, 4'd5, 4'd3, 4'd5, 0);   // 0xFFFF
    run_conv(4'd6, 4'd5, 4'd5, 4'd3, 4'd6, 0);   // wraps to 0, overflow
    run_conv(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 0);   // 0x869F, overflow
    run_conv(4'd0, 4'd0, 4'hA, 4'd0, 4'd0, 0);   // bad digit
    run_conv(4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 0);   // clears err_digit
    run_conv(4'd0, 4'd0, 4'hF, 4'd0, 4'd0, 0);   // bad digit again
    for (int i = 0; i < 4; i++) begin
      logic [3:0] r4, r3, r2, r1, r0;
      r4 = 4'($urandom_range(0, 9)); r3 = 4'($urandom_range(0, 9));
      r2 = 4'($urandom_range(0, 9)); r1 = 4'($urandom_range(0, 9));
      r0 = 4'($urandom_range(0, 9));
      run_conv(r4, r3, r2, r1, r0, 0);
    end
    run_conv(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 5);   // start/digit changes ignored mid-conversion

    // Reset in the middle of a conversion: no done, outputs back to reset values.
    wait_ready();
    D4 = 4'd5; D3 = 4'd4; D2 = 4'd3; D1 = 4'd2; D0 = 4'd1;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midreset");
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_val("no_done_after_abort", dones, 0);

    // Converter is usable again after the abort.
    run_conv(4'd0, 4'd1, 4'd0, 4'd2, 4'd4, 0);   // 1024 = 0x0400

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
